// File: rtl/operand_entry_seq.sv
// operand_entry_seq: debounced ENTER key sequencer that captures A0, then A1/OP, and holds the add/sub result.
module operand_entry_seq #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] SW_VAL,
    input  logic       SW_OP,
    input  logic       KEY_ENTER,
    output logic [3:0] A0,
    output logic [3:0] A1,
    output logic       OP,
    output logic [3:0] F,
    output logic       FLAG,
    output logic [1:0] STATE,
    output logic       RESULT_VALID
);
    typedef enum logic [1:0] {
        ENTER_A0    = 2'b00,
        ENTER_A1    = 2'b01,
        SHOW_RESULT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q, deb_q, deb_d, arm_q;
    logic [1:0]       warm_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             settle_w, enter_w, lt_w;
    logic [3:0]       diff_w;
    logic [4:0]       res_w;
    state_t           state_q;
    logic [3:0]       a0_q, a1_q, f_q;
    logic             op_q, flag_q, valid_q;

    assign settle_w = (sync2_q != deb_q) && (cnt_q == CNT_MAX);
    assign cnt_d    = (sync2_q == deb_q || settle_w) ? '0 : cnt_q + 1'b1;
    assign deb_d    = deb_q ^ settle_w;
    // A key still held through reset must be seen released before it can count as a press.
    assign enter_w  = settle_w & deb_q & arm_q;

    assign lt_w   = a0_q < SW_VAL;
    assign diff_w = lt_w ? SW_VAL - a0_q : a0_q - SW_VAL;
    assign res_w  = SW_OP ? {lt_w, diff_w} : {1'b0, a0_q} + {1'b0, SW_VAL};

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            warm_q  <= 2'b00;
            arm_q   <= 1'b0;
        end else begin
            sync1_q <= KEY_ENTER;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            warm_q  <= {warm_q[0], 1'b1};
            arm_q   <= arm_q | (warm_q[1] & sync2_q);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ENTER_A0;
            a0_q    <= '0;
            a1_q    <= '0;
            op_q    <= 1'b0;
            f_q     <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ENTER_A0: if (enter_w) begin
                    a0_q    <= SW_VAL;
                    state_q <= ENTER_A1;
                end
                ENTER_A1: if (enter_w) begin
                    a1_q            <= SW_VAL;
                    op_q            <= SW_OP;
                    {flag_q, f_q}   <= res_w;
                    state_q         <= SHOW_RESULT;
                    valid_q         <= 1'b1;
                end
                SHOW_RESULT: if (enter_w) begin
                    state_q <= ENTER_A0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ENTER_A0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign A0           = a0_q;
    assign A1           = a1_q;
    assign OP           = op_q;
    assign F            = f_q;
    assign FLAG         = flag_q;
    assign STATE        = state_q;
    assign RESULT_VALID = valid_q;
endmodule

// File: tb/tb_operand_entry_seq.sv
// tb_operand_entry_seq: table vectors, hand sequences and random presses checked against an operand-entry model.
module tb_operand_entry_seq;
    localparam int D = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [3:0] SW_VAL;
    logic       SW_OP;
    logic       KEY_ENTER;
    logic [3:0] A0, A1, F;
    logic       OP, FLAG, RESULT_VALID;
    logic [1:0] STATE;

    int checks = 0;
    int errors = 0;

    int m_st, m_a0, m_a1, m_op, m_f, m_flag;

    typedef struct {
        int a0;
        int a1;
        int op;
        int f;
        int flag;
    } vec_t;

    vec_t vecs[7];

    operand_entry_seq #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .SW_VAL      (SW_VAL),
        .SW_OP       (SW_OP),
        .KEY_ENTER   (KEY_ENTER),
        .A0          (A0),
        .A1          (A1),
        .OP          (OP),
        .F           (F),
        .FLAG        (FLAG),
        .STATE       (STATE),
        .RESULT_VALID(RESULT_VALID)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_a0 = 0; m_a1 = 0; m_op = 0; m_f = 0; m_flag = 0;
    endtask

    // One accepted press walks the three-step entry cycle.
    task automatic model_step(input int v, input int o);
        int d;
        if (m_st == 0) begin
            m_a0 = v;
            m_st = 1;
        end else if (m_st == 1) begin
            m_a1 = v;
            m_op = o;
            if (o == 1) begin
                d = m_a0 - m_a1;
                m_f = (d < 0) ? -d : d;
                m_flag = (d < 0) ? 1 : 0;
            end else begin
                d = m_a0 + m_a1;
                m_f = d % 16;
                m_flag = (d > 15) ? 1 : 0;
            end
            m_st = 2;
        end else begin
            m_st = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".STATE"}, int'(STATE), m_st);
        check({tag, ".A0"}, int'(A0), m_a0);
        check({tag, ".A1"}, int'(A1), m_a1);
        check({tag, ".OP"}, int'(OP), m_op);
        check({tag, ".F"}, int'(F), m_f);
        check({tag, ".FLAG"}, int'(FLAG), m_flag);
        check({tag, ".RESULT_VALID"}, int'(RESULT_VALID), (m_st == 2) ? 1 : 0);
    endtask

    // Hold the key low for `hold` cycles with steady switches, then release and let it settle.
    task automatic press(input int v, input int o, input int hold, output int ch, output int lat);
        logic [1:0] prev;
        int n;
        @(negedge CLOCK_50);
        SW_VAL = 4'(v);
        SW_OP = o[0];
        KEY_ENTER = 1'b0;
        prev = STATE;
        ch = 0;
        lat = -1;
        n = 0;
        repeat (hold) begin
            @(negedge CLOCK_50);
            n++;
            if (STATE != prev) begin
                ch++;
                if (lat < 0) lat = n;
            end
            prev = STATE;
        end
        KEY_ENTER = 1'b1;
        repeat (D + 4) begin
            @(negedge CLOCK_50);
            n++;
            if (STATE != prev) begin
                ch++;
                if (lat < 0) lat = n;
            end
            prev = STATE;
        end
        if (hold >= D) model_step(v, o);
        check("pulse_count", ch, (hold >= D) ? 1 : 0);
    endtask

    initial begin
        int ch, lat;
        vecs[0] = '{9, 8, 0, 1, 1};
        vecs[1] = '{2, 5, 1, 3, 1};
        vecs[2] = '{5, 5, 1, 0, 0};
        vecs[3] = '{15, 15, 0, 14, 1};
        vecs[4] = '{0, 15, 1, 15, 1};
        vecs[5] = '{15, 0, 1, 15, 0};
        vecs[6] = '{7, 8, 0, 15, 0};

        RESET_N = 1'b0;
        KEY_ENTER = 1'b1;
        SW_VAL = 4'd0;
        SW_OP = 1'b0;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check_all("reset");
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        press(3, 0, 10, ch, lat);
        check("first_latency", lat, D + 2);
        check_all("first_a0");
        press(0, 0, 6, ch, lat);
        press(0, 0, 6, ch, lat);
        check_all("back_to_a0");

        for (int i = 0; i < 7; i++) begin
            press(vecs[i].a0, 0, 6, ch, lat);
            press(vecs[i].a1, vecs[i].op, 6, ch, lat);
            check("vec_F", int'(F), vecs[i].f);
            check("vec_FLAG", int'(FLAG), vecs[i].flag);
            check_all("vec_result");
            press(1, 1, 6, ch, lat);
            check("vec_A0_kept", int'(A0), vecs[i].a0);
            check_all("vec_return");
        end

        // Bounce: two short lows around a one-cycle high must not advance.
        @(negedge CLOCK_50); KEY_ENTER = 1'b0;
        repeat (2) @(negedge CLOCK_50); KEY_ENTER = 1'b1;
        @(negedge CLOCK_50); KEY_ENTER = 1'b0;
        repeat (2) @(negedge CLOCK_50); KEY_ENTER = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check_all("bounce");
        press(6, 0, 6, ch, lat);
        check_all("after_bounce");

        // Reset mid-press in ENTER_A1 with the key still held afterwards.
        @(negedge CLOCK_50); KEY_ENTER = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        repeat (2) @(negedge CLOCK_50);
        #3 RESET_N = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        check_all("held_after_reset");
        KEY_ENTER = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check_all("released_after_reset");
        press(7, 0, 6, ch, lat);
        check_all("first_after_reset");

        // Switch activity while showing a result leaves outputs frozen.
        press(12, 0, 6, ch, lat);
        press(7, 1, 6, ch, lat);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLOCK_50);
            SW_VAL = 4'(i);
            SW_OP = i[0];
        end
        @(negedge CLOCK_50);
        check_all("show_frozen");
        press(0, 0, 6, ch, lat);

        for (int k = 0; k < 40; k++) begin
            repeat (3) begin
                @(negedge CLOCK_50);
                SW_VAL = 4'($urandom_range(0, 15));
                SW_OP = 1'($urandom_range(0, 1));
            end
            press(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  int'($urandom_range(1, 12)), ch, lat);
            check_all("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
